pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register, the successor to the fixed 32-bit fetch/decode latch, for use at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a `DATA_W`-bit payload (instruction, PC, control bundle, packed by the instantiating stage) with a valid/ready handshake on both sides. It provides hazard stall, branch flush with bubble injection, and an optional 2-entry skid buffer that removes the combinational ready path. It also keeps saturating stall and flush counters for performance analysis.

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with stall, flush/bubble injection, optional
// 2-entry skid buffer and saturating stall/flush performance counters.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W = 64,
    parameter int unsigned        SKID   = 0,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter int unsigned        CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] DEPTH = (SKID != 0) ? 2'd2 : 2'd1;

    logic [1:0]        occ_q,       occ_d;
    logic [DATA_W-1:0] head_q,      head_d;
    logic [DATA_W-1:0] skid_q,      skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic has_space;
    logic in_fire;
    logic out_fire;

    // Handshake: skid mode looks only at registered occupancy, pass-through
    // mode may reuse the slot being emitted in this same cycle.
    always_comb begin
        if (SKID != 0) begin
            has_space = (occ_q < DEPTH);
        end else begin
            has_space = (occ_q == 2'd0) || out_ready;
        end
        in_ready  = !rst && !flush && !stall && has_space;
        out_valid = (occ_q != 2'd0) && !rst && !stall && !flush;
        out_data  = (occ_q != 2'd0) ? head_q : BUBBLE;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    assign occupancy    = occ_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

    // Next-state: flush empties the stage, otherwise FIFO push/pop by fire.
    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            occ_d  = 2'd0;
            head_d = BUBBLE;
            skid_d = BUBBLE;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            if (stall && (occ_q != 2'd0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            case ({in_fire, out_fire})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = in_data;
                    end else begin
                        skid_d = in_data;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    // Skid entry is promoted only once the head has left.
                    if (occ_q == 2'd2) begin
                        head_d = skid_q;
                        skid_d = BUBBLE;
                    end else begin
                        head_d = BUBBLE;
                    end
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    // Accept only reaches here at occupancy 1: replace head.
                    head_d = in_data;
                end
                default: begin
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= 2'd0;
            head_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three configurations (pass-through, skid with custom bubble, skid with
// 2-bit counters) share one stimulus stream and each has a queue model.
module tb_pipe_stage_reg;

    localparam logic [63:0] BUB1 = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk;
    logic        rst, flush, stall, in_valid, out_ready;
    logic [63:0] in_data;

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [63:0] od0, od1, od2;
    logic [1:0]  oc0, oc1, oc2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .BUBBLE(64'h0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(oc0), .stall_cycles(sc0), .flush_count(fc0));

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .BUBBLE(BUB1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(oc1), .stall_cycles(sc1), .flush_count(fc1));

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .BUBBLE(64'h0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .occupancy(oc2), .stall_cycles(sc2), .flush_count(fc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bounded queue plus two saturating counters per DUT.
    int          m_cap  [3] = '{1, 2, 2};
    longint      m_max  [3] = '{65535, 65535, 3};
    logic [63:0] m_bub  [3] = '{64'h0, BUB1, 64'h0};
    logic [63:0] m_mem  [3][2];
    int          m_size [3] = '{0, 0, 0};
    longint      m_sc   [3] = '{0, 0, 0};
    longint      m_fc   [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic exp_ready(input int k);
        logic room;
        if (m_cap[k] == 2) room = (m_size[k] < 2);
        else               room = (m_size[k] == 0) || out_ready;
        return !rst && !flush && !stall && room;
    endfunction

    function automatic logic exp_valid(input int k);
        return (m_size[k] != 0) && !rst && !stall && !flush;
    endfunction

    function automatic logic [63:0] exp_data(input int k);
        return (m_size[k] != 0) ? m_mem[k][0] : m_bub[k];
    endfunction

    task automatic check_all();
        chk("u0.in_ready",  64'(ir0), 64'(exp_ready(0)));
        chk("u1.in_ready",  64'(ir1), 64'(exp_ready(1)));
        chk("u2.in_ready",  64'(ir2), 64'(exp_ready(2)));
        chk("u0.out_valid", 64'(ov0), 64'(exp_valid(0)));
        chk("u1.out_valid", 64'(ov1), 64'(exp_valid(1)));
        chk("u2.out_valid", 64'(ov2), 64'(exp_valid(2)));
        chk("u0.out_data",  od0, exp_data(0));
        chk("u1.out_data",  od1, exp_data(1));
        chk("u2.out_data",  od2, exp_data(2));
        chk("u0.occupancy", 64'(oc0), 64'(m_size[0]));
        chk("u1.occupancy", 64'(oc1), 64'(m_size[1]));
        chk("u2.occupancy", 64'(oc2), 64'(m_size[2]));
        chk("u0.stall_cycles", 64'(sc0), 64'(m_sc[0]));
        chk("u1.stall_cycles", 64'(sc1), 64'(m_sc[1]));
        chk("u2.stall_cycles", 64'(sc2), 64'(m_sc[2]));
        chk("u0.flush_count",  64'(fc0), 64'(m_fc[0]));
        chk("u1.flush_count",  64'(fc1), 64'(m_fc[1]));
        chk("u2.flush_count",  64'(fc2), 64'(m_fc[2]));
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance model.
    task automatic cyc(input logic r, input logic f, input logic s, input logic iv,
                       input logic [63:0] d, input logic ordy, input bit do_chk);
        logic acc [3];
        logic emt [3];
        rst = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (do_chk) check_all();
        for (int k = 0; k < 3; k++) begin
            acc[k] = iv && exp_ready(k);
            emt[k] = exp_valid(k) && ordy;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_size[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else if (f) begin
                m_size[k] = 0;
                if (m_fc[k] < m_max[k]) m_fc[k]++;
            end else begin
                if (s && m_size[k] != 0 && m_sc[k] < m_max[k]) m_sc[k]++;
                if (emt[k]) begin
                    m_mem[k][0] = m_mem[k][1];
                    m_size[k]--;
                end
                if (acc[k]) begin
                    m_mem[k][m_size[k]] = d;
                    m_size[k]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, ordy, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_data = 64'h0; out_ready = 1'b0;
        @(negedge clk);
        // First reset cycle: registers may still be uninitialised.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        do_reset();
        idle(1'b1);

        // Streaming 0x1..0x8 at full rate.
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'(i), 1'b1, 1'b1);
        chk("stream.last_head", od0, 64'h8);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Skid backpressure: A, B, C with out_ready dropping.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'hB, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'hC, 1'b0, 1'b1);
        chk("skid.full_occ", 64'(oc1), 64'd2);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush at occupancy 2 drops held beats and the offered 0x33.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h22, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 64'h33, 1'b0, 1'b1);
        chk("flush.count", 64'(fc1), 64'd1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Stall for 4 cycles at occupancy 1 holding 0x55.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h55, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("stall.cycles16", 64'(sc0), 64'd4);
        chk("stall.cycles_sat", 64'(sc2), 64'd3);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Counter saturation, then reset with two beats held.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("sat.flush2", 64'(fc2), 64'd3);
        chk("sat.flush16", 64'(fc0), 64'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h88, 1'b0, 1'b1);
        do_reset();
        idle(1'b1);

        // Flush and stall together at occupancy 1.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h99, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("prio.stall", 64'(sc0), 64'd0);
        chk("prio.flush", 64'(fc0), 64'd1);
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                {$urandom, $urandom}, ($urandom_range(2) != 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
